isa_io_master: RTL and testbench

Host-side ISA I/O cycle initiator: turns single-beat requests from an internal controller into ISA-style IOR/IOW bus cycles with programmable setup, strobe and hold times. Drives the address, strobe, AEN and data lines that peripheral responders (the sound, CMS and video register blocks) decode. Honours the responder's ready line for wait states. Intended for the FPGA-hosted bring-up harness and for self-test of the card's register blocks.

---
 rtl/isa_io_master_if.sv | 58 +++++
 rtl/isa_io_master.sv | 164 ++++++++++++++++
 tb/tb_isa_io_master.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/isa_io_master_if.sv
// isa_io_master_if: request/response handshake and ISA bus lines
// between the cycle initiator and its controller/responders.
interface isa_io_master_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_timeout;
  logic [19:0] bus_a;
  logic        bus_ior_l;
  logic        bus_iow_l;
  logic        bus_aen;
  logic [7:0]  bus_d_out;
  logic        bus_d_oe;
  logic [7:0]  bus_d_in;
  logic        bus_rdy;

  modport master (
    input  req_valid,
    input  req_write,
    input  req_addr,
    input  req_wdata,
    input  bus_d_in,
    input  bus_rdy,
    output req_ready,
    output rsp_valid,
    output rsp_rdata,
    output rsp_timeout,
    output bus_a,
    output bus_ior_l,
    output bus_iow_l,
    output bus_aen,
    output bus_d_out,
    output bus_d_oe
  );

  modport slave (
    output req_valid,
    output req_write,
    output req_addr,
    output req_wdata,
    output bus_d_in,
    output bus_rdy,
    input  req_ready,
    input  rsp_valid,
    input  rsp_rdata,
    input  rsp_timeout,
    input  bus_a,
    input  bus_ior_l,
    input  bus_iow_l,
    input  bus_aen,
    input  bus_d_out,
    input  bus_d_oe
  );
endinterface

// File: rtl/isa_io_master.sv
// isa_io_master: ISA IOR/IOW cycle initiator, programmable setup/strobe/hold.
// Define ISA_IO_TIMEOUT_EN to abort cycles stuck on bus_rdy low.
module isa_io_master #(
  parameter int SETUP_CYC   = 2,
  parameter int STROBE_CYC  = 6,
  parameter int HOLD_CYC    = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic reset,
  isa_io_master_if.master io
);

  if (SETUP_CYC < 1 || STROBE_CYC < 3 ||
      HOLD_CYC < 1 || TIMEOUT_CYC < 1) begin : g_bad_param
    $error("isa_io_master: illegal timing parameter");
  end

  localparam int M1 =
    (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
  localparam int CMAX = (M1 > HOLD_CYC) ? M1 : HOLD_CYC;
  localparam int CW = $clog2(CMAX + 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic        accept;
  logic        fin;
  logic        wr_q;
  logic [15:0] a_q;
  logic [7:0]  wd_q;
  logic [7:0]  rdata_q;
  logic        rsp_q;

`ifdef ISA_IO_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] wcnt;
  logic [TW-1:0] wcnt_n;
  logic        abort;
  logic        to_q;
`endif

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    accept  = 1'b0;
    fin     = 1'b0;
`ifdef ISA_IO_TIMEOUT_EN
    abort   = 1'b0;
    wcnt_n  = (state == STROBE) ? wcnt : '0;
`endif
    unique case (state)
      IDLE: begin
        if (io.req_valid) begin
          accept  = 1'b1;
          state_n = SETUP;
          cnt_n   = CW'(SETUP_CYC - 1);
        end
      end
      SETUP: begin
        if (cnt == '0) begin
          state_n = STROBE;
          cnt_n   = CW'(STROBE_CYC - 1);
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      STROBE: begin
        // counter parks at zero while the responder holds bus_rdy low
        if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else if (io.bus_rdy) begin
          fin = 1'b1;
        end
`ifdef ISA_IO_TIMEOUT_EN
        else if (wcnt == TW'(TIMEOUT_CYC)) begin
          fin   = 1'b1;
          abort = 1'b1;
        end else begin
          wcnt_n = wcnt + 1'b1;
        end
`endif
        if (fin) begin
          state_n = HOLD;
          cnt_n   = CW'(HOLD_CYC - 1);
        end
      end
      HOLD: begin
        if (cnt == '0) begin
          state_n = IDLE;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      wr_q    <= 1'b0;
      a_q     <= '0;
      wd_q    <= '0;
      rdata_q <= '0;
      rsp_q   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      rsp_q <= (state == HOLD) && (state_n == IDLE);
      if (accept) begin
        wr_q <= io.req_write;
        a_q  <= io.req_addr;
        wd_q <= io.req_wdata;
      end
      if (fin && !wr_q) begin
        rdata_q <= io.bus_d_in;
      end
`ifdef ISA_IO_TIMEOUT_EN
      if (abort) begin
        rdata_q <= 8'hFF;
      end
`endif
    end
  end

`ifdef ISA_IO_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wcnt <= '0;
      to_q <= 1'b0;
    end else begin
      wcnt <= wcnt_n;
      if (fin) begin
        to_q <= abort;
      end
    end
  end

  assign io.rsp_timeout = rsp_q & to_q;
`else
  assign io.rsp_timeout = 1'b0;
`endif

  assign io.req_ready = (state == IDLE);
  assign io.bus_aen   = (state == IDLE);
  assign io.bus_ior_l = !((state == STROBE) && !wr_q);
  assign io.bus_iow_l = !((state == STROBE) && wr_q);
  assign io.bus_d_oe  = (state != IDLE) && wr_q;
  assign io.bus_d_out = wd_q;
  assign io.bus_a     = {4'h0, a_q};
  assign io.rsp_valid = rsp_q;
  assign io.rsp_rdata = rdata_q;

endmodule

// File: tb/tb_isa_io_master.sv
// tb_isa_io_master: timeline model of ISA cycles checked every cycle,
// plus directed latency/width checks on the scenarios of interest.
module tb_isa_io_master;
  localparam int S  = 2;
  localparam int T  = 6;
  localparam int H  = 2;
  localparam int TO = 20;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int acc = 0;

  isa_io_master_if io();

  isa_io_master #(
    .SETUP_CYC(S),
    .STROBE_CYC(T),
    .HOLD_CYC(H),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .io(io)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Model: a transaction is a timeline of cycle numbers k since accept.
  bit          m_busy = 0;
  bit          m_wr = 0;
  bit          m_rsp = 0;
  bit          m_to = 0;
  int          m_k = 0;
  int          m_end = 0;
  logic [15:0] m_a = '0;
  logic [7:0]  m_wd = '0;
  logic [7:0]  m_rd = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy = 0; m_wr = 0; m_rsp = 0; m_to = 0;
      m_k = 0; m_end = 0;
      m_a = '0; m_wd = '0; m_rd = '0;
    end else begin
      m_rsp = 0;
      if (!m_busy) begin
        if (io.req_valid) begin
          m_busy = 1; m_k = 1; m_end = 0; m_to = 0;
          m_wr = io.req_write;
          m_a = io.req_addr;
          m_wd = io.req_wdata;
        end
      end else begin
        if (m_end == 0 && m_k >= S + T) begin
          if (io.bus_rdy) begin
            m_end = m_k;
            if (!m_wr) m_rd = io.bus_d_in;
          end
`ifdef ISA_IO_TIMEOUT_EN
          else if (m_k - (S + T) == TO) begin
            m_end = m_k; m_to = 1; m_rd = 8'hFF;
          end
`endif
        end
        if (m_end != 0 && m_k == m_end + H) begin
          m_busy = 0; m_rsp = 1;
        end else begin
          m_k++;
        end
      end
    end
  end

  always @(negedge clk) begin : cmp
    bit st;
    st = m_busy && m_k > S && (m_end == 0 || m_k <= m_end);
    check("req_ready", io.req_ready, !m_busy);
    check("bus_aen", io.bus_aen, !m_busy);
    check("bus_ior_l", io.bus_ior_l, !(st && !m_wr));
    check("bus_iow_l", io.bus_iow_l, !(st && m_wr));
    check("bus_d_oe", io.bus_d_oe, m_busy && m_wr);
    check("bus_d_out", io.bus_d_out, m_wd);
    check("bus_a", io.bus_a, {4'h0, m_a});
    check("rsp_valid", io.rsp_valid, m_rsp);
    check("rsp_rdata", io.rsp_rdata, m_rd);
    check("rsp_timeout", io.rsp_timeout, m_rsp && m_to);
  end

  // Bus activity counters for the directed checks
  int n_ior, n_iow, n_oe, n_aen, n_rsp;
  int s_first, s_last, oe_first;
  always @(negedge clk) if (!reset) begin
    if (!io.bus_ior_l) n_ior++;
    if (!io.bus_iow_l) n_iow++;
    if (!io.bus_ior_l || !io.bus_iow_l) begin
      if (s_first < 0) s_first = cyc - acc;
      s_last = cyc - acc;
    end
    if (io.bus_d_oe) begin
      if (oe_first < 0) oe_first = cyc - acc;
      n_oe++;
    end
    if (io.bus_aen) n_aen++;
    if (io.rsp_valid) n_rsp++;
  end

  task automatic clr();
    n_ior = 0; n_iow = 0; n_oe = 0; n_aen = 0; n_rsp = 0;
    s_first = -1; s_last = -1; oe_first = -1;
  endtask

  task automatic start(input bit w, input logic [15:0] a,
                       input logic [7:0] d, input bit keep);
    int n = 0;
    @(posedge clk); #1;
    io.req_valid = 1; io.req_write = w;
    io.req_addr = a; io.req_wdata = d;
    do begin @(negedge clk); n++; end
    while (!io.req_ready && n < 50);
    if (!io.req_ready) check("accept_wait", 0, 1);
    @(posedge clk); #1;
    acc = cyc - 1;
    if (!keep) begin
      io.req_valid = 0;
      io.req_write = ~w;
      io.req_addr = 16'hFFFF;
      io.req_wdata = 8'h5A;
    end
  endtask

  task automatic wait_rsp(output int lat, output logic [7:0] rd,
                          output logic to);
    int n = 0;
    lat = -1; rd = 'x; to = 'x;
    while (n < 100) begin
      @(negedge clk); n++;
      if (io.rsp_valid) begin
        lat = cyc - acc; rd = io.rsp_rdata; to = io.rsp_timeout;
        break;
      end
    end
  endtask

  int lat, c1;
  logic [7:0] rd;
  logic to;

  initial begin
    io.req_valid = 0; io.req_write = 0;
    io.req_addr = '0; io.req_wdata = '0;
    io.bus_d_in = '0; io.bus_rdy = 1;
    clr();
    @(negedge clk);
    check("rst_ready", io.req_ready, 1);
    check("rst_aen", io.bus_aen, 1);
    check("rst_strobes", {io.bus_ior_l, io.bus_iow_l}, 2'b11);
    check("rst_a", io.bus_a, 0);
    check("rst_rsp", io.rsp_valid, 0);
    @(posedge clk); #1 reset = 0;

    // write 0x388 <- 0x20
    clr();
    start(1, 16'h0388, 8'h20, 0);
    wait_rsp(lat, rd, to);
    check("wr_lat", lat, 11);
    check("wr_iow_cycles", n_iow, 6);
    check("wr_ior_cycles", n_ior, 0);
    check("wr_strobe_first", s_first, 3);
    check("wr_strobe_last", s_last, 8);
    check("wr_oe_cycles", n_oe, 10);
    check("wr_oe_first", oe_first, 1);
    check("wr_rdata_keep", rd, 8'h00);

    // read 0x389, responder returns 0xA5
    io.bus_d_in = 8'hA5;
    clr();
    start(0, 16'h0389, 8'h00, 0);
    wait_rsp(lat, rd, to);
    check("rd_lat", lat, 11);
    check("rd_ior_cycles", n_ior, 6);
    check("rd_oe_cycles", n_oe, 0);
    check("rd_data", rd, 8'hA5);

    // wait states: bus_rdy low strobe cycles 2..11
    io.bus_d_in = 8'h3C;
    clr();
    start(0, 16'h0222, 8'h00, 0);
    repeat (3) @(posedge clk);
    #1 io.bus_rdy = 0;
    repeat (10) @(posedge clk);
    #1 io.bus_rdy = 1;
    wait_rsp(lat, rd, to);
    check("ws_lat", lat, 17);
    check("ws_strobe_cycles", n_ior, 12);
    check("ws_timeout", to, 0);
    check("ws_data", rd, 8'h3C);

`ifdef ISA_IO_TIMEOUT_EN
    io.bus_rdy = 0;
    io.bus_d_in = 8'h12;
    clr();
    start(0, 16'h0201, 8'h00, 0);
    wait_rsp(lat, rd, to);
    check("to_lat", lat, 31);
    check("to_strobe_cycles", n_ior, 26);
    check("to_flag", to, 1);
    check("to_data", rd, 8'hFF);
    io.bus_rdy = 1;
    io.bus_d_in = 8'h77;
    clr();
    start(0, 16'h0201, 8'h00, 0);
    wait_rsp(lat, rd, to);
    check("after_to_lat", lat, 11);
    check("after_to_flag", to, 0);
    check("after_to_data", rd, 8'h77);
`endif

    // back-to-back writes with req_valid held
    clr();
    start(1, 16'h0220, 8'h11, 1);
    n_aen = 0;
    io.req_addr = 16'h0221; io.req_wdata = 8'h22;
    wait_rsp(lat, rd, to);
    check("b2b_lat1", lat, 11);
    c1 = cyc;
    @(posedge clk); #1;
    acc = cyc - 1;
    io.req_valid = 0;
    check("b2b_aen_gap", n_aen, 1);
    wait_rsp(lat, rd, to);
    check("b2b_lat2", lat, 11);
    check("b2b_spacing", cyc - c1, 11);

    // reset during the strobe of a write
    clr();
    start(1, 16'h0300, 8'h99, 0);
    repeat (4) @(posedge clk);
    #3;
    check("pre_rst_iow", io.bus_iow_l, 0);
    reset = 1;
    #1;
    check("mid_rst_iow", io.bus_iow_l, 1);
    check("mid_rst_aen", io.bus_aen, 1);
    check("mid_rst_oe", io.bus_d_oe, 0);
    check("mid_rst_a", io.bus_a, 0);
    @(posedge clk); @(posedge clk);
    #1 reset = 0;
    n_rsp = 0;
    repeat (15) @(negedge clk);
    check("post_rst_rsp", n_rsp, 0);
    check("post_rst_ready", io.req_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
